// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer helpers shared by the write-side and read-side FIFO controllers.
// Gray/binary conversions work on a 32-bit container. Callers zero-extend
// their pointer into it and cast the result back to the pointer width.
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   // Ceiling log2. clog2(7) = 3 and clog2(8) = 3.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a multi-bit Gray-coded bus.
// The source changes at most one bit per update, so the bus stays coherent.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] meta_p0;

   // Metastability stage, then the stable output stage. Both clear asynchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_p0 <= '0;
         o_q     <= '0;
      end else begin
         meta_p0 <= i_d;
         o_q     <= meta_p0;
      end
   end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of an asynchronous FIFO.
// It keeps the binary write pointer and publishes it to the read domain in Gray code.
// It also synchronizes the read pointer, and derives full, level and overflow from it.
// Optional feature: define FIFO_WR_CTRL_AFULL_EN to add the o_almost_full output.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int DATA_DEPTH  = 64,
   parameter  int AFULL_LEVEL = DATA_DEPTH - 4,
   localparam int AW          = clog2(DATA_DEPTH - 1)
) (
   input  logic                  i_wrclk,
   input  logic                  i_wrst_n,
   input  logic                  i_wr_req,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [AW:0]           i_rd_gray,
   output logic                  o_wren,
   output logic [AW-1:0]         o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic [AW:0]           o_wr_gray,
   output logic                  o_full,
   output logic [AW:0]           o_wr_level,
   output logic                  o_overflow
`ifdef FIFO_WR_CTRL_AFULL_EN
   ,
   output logic                  o_almost_full
`endif
);

   localparam int PW = AW + 1;

   logic [AW:0] wbin;
   logic [AW:0] wbin_next;
   logic [AW:0] wgray_next;
   logic [AW:0] rgray_s;
   logic [AW:0] rbin_s;
   logic [AW:0] level_next;
   logic        full_next;

   // The read pointer crosses into i_wrclk here.
   sync_2ff #(.WIDTH(PW)) u_rd_sync (
      .i_clk   (i_wrclk),
      .i_rst_n (i_wrst_n),
      .i_d     (i_rd_gray),
      .o_q     (rgray_s)
   );

   // RAM port: the write lands on the same edge that advances wbin.
   // Reset gates the enable immediately, without waiting for a clock edge.
   assign o_wren  = i_wr_req & ~o_full & i_wrst_n;
   assign o_waddr = wbin[AW-1:0];
   assign o_wdata = i_wr_data;

   // Next pointer and the flags derived from it.
   // Full means the write pointer is exactly one lap (DATA_DEPTH) ahead of the read pointer.
   // In Gray code, that is the read pointer with its top two bits inverted.
   always_comb begin
      wbin_next  = wbin + {{AW{1'b0}}, o_wren};
      wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
      rbin_s     = PW'(gray2bin(PTR_MAX_W'(rgray_s)));
      level_next = wbin_next - rbin_s;
      full_next  = (wgray_next == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
   end

   // Pointer and status registers. A request made while full is dropped and flagged.
   always_ff @(posedge i_wrclk or negedge i_wrst_n) begin
      if (!i_wrst_n) begin
         wbin       <= '0;
         o_wr_gray  <= '0;
         o_full     <= 1'b0;
         o_wr_level <= '0;
         o_overflow <= 1'b0;
      end else begin
         wbin       <= wbin_next;
         o_wr_gray  <= wgray_next;
         o_full     <= full_next;
         o_wr_level <= level_next;
         o_overflow <= i_wr_req & o_full;
      end
   end

`ifdef FIFO_WR_CTRL_AFULL_EN
   // Almost-full is registered from the same next level, so it moves together with o_wr_level.
   always_ff @(posedge i_wrclk or negedge i_wrst_n) begin
      if (!i_wrst_n) o_almost_full <= 1'b0;
      else           o_almost_full <= (int'(level_next) >= AFULL_LEVEL);
   end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed bench for fifo_wr_ctrl (DATA_DEPTH=8, AFULL_LEVEL=6).
// A count-based reference model of the write side is checked on every falling edge.
// Directed literal checks pin the model at the interesting points.
module tb_fifo_wr_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AFL   = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req;
   logic [DW-1:0] wdata;
   logic [3:0]    rd_gray;
   logic          wren;
   logic [2:0]    waddr;
   logic [DW-1:0] wdata_o;
   logic [3:0]    wr_gray;
   logic          full;
   logic [3:0]    level;
   logic          ovf;
`ifdef FIFO_WR_CTRL_AFULL_EN
   logic          afull;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_wr_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
      .i_wrclk    (clk),
      .i_wrst_n   (rst_n),
      .i_wr_req   (req),
      .i_wr_data  (wdata),
      .i_rd_gray  (rd_gray),
      .o_wren     (wren),
      .o_waddr    (waddr),
      .o_wdata    (wdata_o),
      .o_wr_gray  (wr_gray),
      .o_full     (full),
      .o_wr_level (level),
      .o_overflow (ovf)
`ifdef FIFO_WR_CTRL_AFULL_EN
      ,
      .o_almost_full (afull)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int g2b(input int g);
      int b;
      b = 0;
      for (int i = 3; i >= 0; i--) b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
      return b;
   endfunction

   function automatic logic [3:0] b2g(input int b);
      int g;
      g = b ^ (b >> 1);
      return 4'(g);
   endfunction

   // The reference model counts accepted writes and holds the read pointer as seen
   // two edges late. Level is the distance between the two; full means level == DEPTH.
   int m_w, m_level, m_s1, m_s2;
   bit m_full, m_ovf, m_af;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_w = 0; m_level = 0; m_s1 = 0; m_s2 = 0;
         m_full = 0; m_ovf = 0; m_af = 0;
      end else begin
         m_ovf   = req && m_full;
         if (req && !m_full) m_w = (m_w + 1) % 16;
         m_level = (m_w - g2b(m_s2) + 16) % 16;
         m_full  = (m_level == DEPTH);
         m_af    = (m_level >= AFL);
         m_s2    = m_s1;
         m_s1    = int'(rd_gray);
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      chk("m_wren",   32'(wren),    32'(req && !m_full && rst_n));
      chk("m_waddr",  32'(waddr),   32'(m_w % DEPTH));
      chk("m_wdata",  32'(wdata_o), 32'(wdata));
      chk("m_wrgray", 32'(wr_gray), 32'(b2g(m_w)));
      chk("m_full",   32'(full),    32'(m_full));
      chk("m_level",  32'(level),   32'(m_level));
      chk("m_ovf",    32'(ovf),     32'(m_ovf));
`ifdef FIFO_WR_CTRL_AFULL_EN
      chk("m_afull",  32'(afull),   32'(m_af));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 1'b0; rd_gray = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected end before 100000");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; wdata = '0; rd_gray = 4'd0;
      #1;
      chk("rst_full",  32'(full),    32'd0);
      chk("rst_level", 32'(level),   32'd0);
      chk("rst_gray",  32'(wr_gray), 32'd0);
      chk("rst_wren",  32'(wren),    32'd0);
      do_reset();

      // Eight writes with the reader idle fill the FIFO.
      for (int i = 0; i < 8; i++) begin
         req = 1'b1; wdata = 8'($urandom);
         #1;
         chk("fill_waddr", 32'(waddr), 32'(i));
         chk("fill_wren",  32'(wren),  32'd1);
         tick();
      end
      chk("fill_full",  32'(full),    32'd1);
      chk("fill_level", 32'(level),   32'd8);
      chk("fill_gray",  32'(wr_gray), 32'hC);

      // A ninth request while full is dropped and flagged for one cycle.
      #1;
      chk("ovf_wren", 32'(wren), 32'd0);
      tick();
      chk("ovf_pulse", 32'(ovf),     32'd1);
      chk("ovf_gray",  32'(wr_gray), 32'hC);
      chk("ovf_waddr", 32'(waddr),   32'd0);
      req = 1'b0;
      tick();
      chk("ovf_clear", 32'(ovf),     32'd0);
      chk("ovf_gray2", 32'(wr_gray), 32'hC);

      // One entry is freed; full drops exactly three edges later.
      rd_gray = 4'b0001;
      tick();
      chk("free_e1", 32'(full), 32'd1);
      tick();
      chk("free_e2", 32'(full), 32'd1);
      tick();
      chk("free_e3",  32'(full),  32'd0);
      chk("free_lvl", 32'(level), 32'd7);

      // Sixteen writes with the reader keeping pace wrap the pointer.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req = 1'b1; wdata = 8'($urandom);
         #1;
         chk("wrap_waddr", 32'(waddr), 32'(i % DEPTH));
         tick();
         rd_gray = b2g(i + 1);
         if (i == 14) chk("wrap_gray15", 32'(wr_gray), 32'h8);
      end
      req = 1'b0;
      chk("wrap_gray0", 32'(wr_gray), 32'h0);
      chk("wrap_addr0", 32'(waddr),   32'd0);
      tick();
      tick();
      tick();

      // Reset taken at level 5 with a request pending clears everything at once.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req = 1'b1; wdata = 8'($urandom);
         tick();
      end
      chk("pre_level", 32'(level), 32'd5);
      #1;
      chk("pre_wren", 32'(wren), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_wren",  32'(wren),    32'd0);
      chk("arst_level", 32'(level),   32'd0);
      chk("arst_full",  32'(full),    32'd0);
      chk("arst_gray",  32'(wr_gray), 32'd0);
      chk("arst_ovf",   32'(ovf),     32'd0);
      chk("arst_waddr", 32'(waddr),   32'd0);

      // Level 5 to 6 crosses the almost-full threshold.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req = 1'b1; wdata = 8'($urandom);
         tick();
         if (i == 4) begin
            chk("af_lvl5", 32'(level), 32'd5);
`ifdef FIFO_WR_CTRL_AFULL_EN
            chk("af_off5", 32'(afull), 32'd0);
`endif
         end
      end
      req = 1'b0;
      chk("af_lvl6", 32'(level), 32'd6);
`ifdef FIFO_WR_CTRL_AFULL_EN
      chk("af_on6", 32'(afull), 32'd1);
`endif
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 64, entry count; must be a power of 2 and at least 4.
REQ-003 SHALL have parameter AFULL_LEVEL, default DATA_DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL define derived AW = clog2(DATA_DEPTH-1), the RAM address width.
REQ-005 SHALL have port i_wrclk, input, 1, write-domain clock.
REQ-006 SHALL have port i_wrst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_wr_req, input, 1, producer write request.
REQ-008 SHALL have port i_wr_data, input, DATA_WIDTH, producer payload.
REQ-009 SHALL have port i_rd_gray, input, AW+1, read pointer in Gray code, asynchronous to i_wrclk.
REQ-010 SHALL have port o_wren, output, 1, RAM write enable.
REQ-011 SHALL have port o_waddr, output, AW, RAM write address.
REQ-012 SHALL have port o_wdata, output, DATA_WIDTH, RAM write data.
REQ-013 SHALL have port o_wr_gray, output, AW+1, registered write pointer in Gray code, sent to the read domain.
REQ-014 SHALL have port o_full, output, 1, FIFO full.
REQ-015 SHALL have port o_wr_level, output, AW+1, fill level as seen by the write side, range 0..DATA_DEPTH.
REQ-016 SHALL have port o_overflow, output, 1, one-cycle pulse flagging a write request dropped while full.

Function
REQ-017 SHALL accept a write when i_wr_req=1 and o_full=0.
REQ-018 SHALL drive o_wren as i_wr_req AND NOT o_full AND i_wrst_n, combinationally.
REQ-019 SHALL drive o_waddr from wbin[AW-1:0] and pass o_wdata through from i_wr_data, both combinationally; the RAM captures the write on the same i_wrclk edge.
REQ-020 SHALL keep an AW+1-bit binary pointer wbin that increments by 1 per accepted write and wraps from 2*DATA_DEPTH-1 to 0.
REQ-021 SHALL register o_wr_gray = wbin_next XOR (wbin_next>>1), so o_wr_gray changes at most one bit per edge.
REQ-022 SHALL pass i_rd_gray through a 2-flop synchronizer to produce rgray_s.
REQ-023 SHALL register o_full as (gray(wbin_next) == rgray_s with its two MSBs inverted).
REQ-024 SHALL assert o_full on the edge that accepts the write reaching DATA_DEPTH entries.
REQ-025 SHALL deassert o_full exactly 3 i_wrclk edges after an i_rd_gray change that frees space.
REQ-026 SHALL register o_wr_level = wbin_next - gray2bin(rgray_s), computed modulo 2^(AW+1).
REQ-027 SHALL drop a request made while full: o_wren=0, wbin unchanged, and o_overflow=1 for exactly the next cycle.
REQ-028 SHALL never let o_wr_level exceed DATA_DEPTH or wrap below 0 under legal read-side behaviour.

Reset
REQ-029 SHALL clear wbin, o_wr_gray, both synchronizer flops, o_full, o_wr_level and o_overflow to 0 asynchronously on i_wrst_n=0.
REQ-030 SHALL force o_wren=0 immediately when reset is asserted mid-burst and ignore i_wr_req during reset.
REQ-031 SHALL release reset synchronously to i_wrclk; the first write may be accepted on the first edge after release.

Configuration
REQ-032 SHALL, when macro FIFO_WR_CTRL_AFULL_EN is defined, add output port o_almost_full (1 bit), registered as o_wr_level_next >= AFULL_LEVEL, reset to 0.
REQ-033 SHALL, without FIFO_WR_CTRL_AFULL_EN, omit o_almost_full and its logic; all other behaviour is identical.

Structure
REQ-034 SHALL take the clog2, bin2gray and gray2bin functions from shared package fifo_pkg, reused by the read-side controller.
REQ-035 SHALL implement the synchronizer as sub-module sync_2ff with parameter WIDTH, reset value 0 and asynchronous active-low reset.

Verification (bench parameters DATA_DEPTH=8, AFULL_LEVEL=6)
REQ-036 SHALL cover: after reset, 8 consecutive writes with i_rd_gray=0 -> o_waddr 0..7, o_full=1 after the 8th edge, o_wr_level=8.
REQ-037 SHALL cover: while full, 9th request -> o_wren=0, o_overflow high for 1 cycle, o_wr_gray stays 4'b1100.
REQ-038 SHALL cover: from full, i_rd_gray set to 4'b0001 -> o_full=0 exactly 3 edges later and o_wr_level=7.
REQ-039 SHALL cover: 16 writes with i_rd_gray tracking the write side -> o_wr_gray = 4'b1000 at wbin=15, then wraps to 4'b0000 with o_waddr=0.
REQ-040 SHALL cover, with FIFO_WR_CTRL_AFULL_EN: level 5->6 -> o_almost_full rises on the same edge as o_wr_level=6; without the macro the port is absent.
REQ-041 SHALL cover: reset asserted at level 5 with i_wr_req=1 -> o_wren=0 and all outputs 0 without waiting for a clock edge.
